// File: rtl/cdb_broadcaster_pkg.sv
// Shared Tomasulo definitions: bus widths, the CDB packet seen by every
// receiver, and the functional-unit index map.
package tomasulo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;
    localparam int FU_LD  = 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Functional-unit result handshake plus the broadcast side of the CDB.
// The master modport is the core (units and receivers); the slave is the broadcaster.
interface cdb_broadcaster_if
    import tomasulo_pkg::*;
#(
    parameter int N_FU  = 3,
    parameter int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1
);

    logic [N_FU-1:0]        fu_valid;
    logic [N_FU-1:0]        fu_ready;
    logic [N_FU*TAG_W-1:0]  fu_tag;
    logic [N_FU*DATA_W-1:0] fu_result;
    logic                   flush;

    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_value;
    logic [SRC_W-1:0]       cdb_src;

    modport master (
        output fu_valid, fu_tag, fu_result, flush,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
    );

    modport slave (
        input  fu_valid, fu_tag, fu_result, flush,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
    );

endinterface

// File: rtl/cdb_broadcaster_src_fifo.sv
// Circular result buffer for one functional unit; full/empty come only from
// the registered count, so a pop never frees a slot in the same cycle.
module cdb_src_fifo
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [TAG_W-1:0]  headTag_o,
    output logic [DATA_W-1:0] headValue_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic [TAG_W-1:0]  tagMem_q   [DEPTH];
    logic [DATA_W-1:0] valueMem_q [DEPTH];
    logic              doPush, doPop;
    logic [AW-1:0]     wrIdx, rdIdx;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o      = (count_q == PTR_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign doPush      = push_i && !full_o;
    assign doPop       = pop_i && !empty_o;
    assign wrIdx       = AW'(wrPtr_q);
    assign rdIdx       = AW'(rdPtr_q);
    assign headTag_o   = tagMem_q[rdIdx];
    assign headValue_o = valueMem_q[rdIdx];

    always_comb begin
        wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop  ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flush shares the reset path: pointers and count clear, pushes are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            tagMem_q[wrIdx]   <= tag_i;
            valueMem_q[wrIdx] <= value_i;
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB producer: per-unit result FIFOs feeding a round-robin arbiter that
// drives one registered (tag, value) broadcast per cycle.
module cdb_broadcaster
    import tomasulo_pkg::*;
#(
    parameter int N_FU  = 3,
    parameter int DEPTH = 2
) (
    input logic CLK,
    input logic RST_N,
    cdb_broadcaster_if.slave bus
);

    localparam int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]   fifoFull, fifoEmpty, pushEn, popEn;
    logic [TAG_W-1:0]  headTag   [N_FU];
    logic [DATA_W-1:0] headValue [N_FU];

    logic              grantValid;
    logic [SRC_W-1:0]  grantIdx;
    logic [SRC_W:0]    probeSum;
    logic [SRC_W-1:0]  probeIdx;

    cdb_pkt_t          cdbPkt_q, cdbPkt_d;
    logic [SRC_W-1:0]  cdbSrc_q, cdbSrc_d;
    logic [SRC_W-1:0]  rr_q, rr_d;

    for (genvar i = 0; i < N_FU; i++) begin : gSrc
        assign pushEn[i] = bus.fu_valid[i] && !fifoFull[i];
        assign popEn[i]  = grantValid && (grantIdx == SRC_W'(i));

        cdb_src_fifo #(.DEPTH(DEPTH)) uFifo (
            .clk         (CLK),
            .rst_n       (RST_N),
            .flush_i     (bus.flush),
            .push_i      (pushEn[i]),
            .tag_i       (bus.fu_tag[i*TAG_W +: TAG_W]),
            .value_i     (bus.fu_result[i*DATA_W +: DATA_W]),
            .pop_i       (popEn[i]),
            .full_o      (fifoFull[i]),
            .empty_o     (fifoEmpty[i]),
            .headTag_o   (headTag[i]),
            .headValue_o (headValue[i])
        );
    end

    assign bus.fu_ready = ~fifoFull;

    // Search upward from rr, wrapping at N_FU; the first non-empty FIFO wins.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        probeSum   = '0;
        probeIdx   = '0;
        for (int k = 0; k < N_FU; k++) begin
            probeSum = {1'b0, rr_q} + (SRC_W+1)'(k);
            if (probeSum >= (SRC_W+1)'(N_FU)) begin
                probeSum = probeSum - (SRC_W+1)'(N_FU);
            end
            probeIdx = probeSum[SRC_W-1:0];
            if (!grantValid && !fifoEmpty[probeIdx]) begin
                grantValid = 1'b1;
                grantIdx   = probeIdx;
            end
        end
    end

    always_comb begin
        cdbPkt_d       = cdbPkt_q;
        cdbPkt_d.valid = 1'b0;
        cdbSrc_d       = cdbSrc_q;
        rr_d           = rr_q;
        if (grantValid && !bus.flush) begin
            cdbPkt_d.valid = 1'b1;
            cdbPkt_d.tag   = headTag[grantIdx];
            cdbPkt_d.value = headValue[grantIdx];
            cdbSrc_d       = grantIdx;
            rr_d           = (grantIdx == SRC_W'(N_FU - 1)) ? '0 : grantIdx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cdbPkt_q <= '0;
            cdbSrc_q <= '0;
            rr_q     <= '0;
        end else begin
            cdbPkt_q <= cdbPkt_d;
            cdbSrc_q <= cdbSrc_d;
            rr_q     <= rr_d;
        end
    end

    assign bus.cdb_valid = cdbPkt_q.valid;
    assign bus.cdb_tag   = cdbPkt_q.tag;
    assign bus.cdb_value = cdbPkt_q.value;
    assign bus.cdb_src   = cdbSrc_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, single push, simultaneous push,
// fairness, backpressure and flush, with hand-computed CDB sequences.
module tb_cdb_broadcaster;
    import tomasulo_pkg::*;

    localparam int N_FU  = 3;
    localparam int DEPTH = 2;
    localparam int SRC_W = 2;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   totalCount = 0;
    int   badCount   = 0;

    cdb_broadcaster_if #(.N_FU(N_FU), .SRC_W(SRC_W)) bus ();

    cdb_broadcaster #(.N_FU(N_FU), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Inputs change 1ns after an edge, so each call covers exactly one edge.
    task automatic applyStimulus(input logic [2:0] valid,
                                 input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic flushIn);
        bus.fu_valid  = valid;
        bus.fu_tag    = {t2, t1, t0};
        bus.fu_result = {d2, d1, d0};
        bus.flush     = flushIn;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic applyReset();
        RST_N = 1'b0;
        idle();
        RST_N = 1'b1;
    endtask

    task automatic expectCdb(input string name, input logic [2:0] tag,
                             input logic [1:0] src, input logic [31:0] value);
        checkOutput({name, ".valid"}, 32'(bus.cdb_valid), 32'd1);
        checkOutput({name, ".tag"},   32'(bus.cdb_tag),   32'(tag));
        checkOutput({name, ".src"},   32'(bus.cdb_src),   32'(src));
        checkOutput({name, ".value"}, bus.cdb_value,      value);
    endtask

    task automatic expectIdle(input string name);
        checkOutput({name, ".valid"}, 32'(bus.cdb_valid), 32'd0);
    endtask

    task automatic expectReady(input string name, input logic [2:0] ready);
        checkOutput({name, ".ready"}, 32'(bus.fu_ready), 32'(ready));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with every unit trying to push.
        RST_N = 1'b0;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(3'b111, 3'd1, 3'd2, 3'd3, 32'h11, 32'h22, 32'h33, 1'b0);
            expectIdle("rst");
            checkOutput("rst.tag",   32'(bus.cdb_tag), 32'd0);
            checkOutput("rst.value", bus.cdb_value,    32'd0);
            checkOutput("rst.src",   32'(bus.cdb_src), 32'd0);
        end
        expectReady("rst", 3'b111);
        RST_N = 1'b1;
        idle();
        expectIdle("rstRel1");
        expectReady("rstRel", 3'b111);
        idle();
        expectIdle("rstRel2");

        // Single push on the multiplier.
        applyStimulus(3'b010, 3'd0, 3'd3, 3'd0, 32'h0, 32'h0000_00A5, 32'h0, 1'b0);
        expectIdle("single.nobypass");
        idle();
        expectCdb("single", 3'd3, 2'(FU_MUL), 32'h0000_00A5);
        idle();
        expectIdle("single.after");
        checkOutput("single.holdTag", 32'(bus.cdb_tag), 32'd3);

        // All three units push at once with rr back at zero.
        applyReset();
        applyStimulus(3'b111, 3'd1, 3'd2, 3'd3, 32'd10, 32'd20, 32'd30, 1'b0);
        expectIdle("simul.push");
        idle();
        expectCdb("simul0", 3'd1, 2'(FU_ADD), 32'd10);
        idle();
        expectCdb("simul1", 3'd2, 2'(FU_MUL), 32'd20);
        idle();
        expectCdb("simul2", 3'd3, 2'(FU_LD), 32'd30);
        idle();
        expectIdle("simul.done");

        // Units 0 and 2 continuously valid: grants must alternate.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b101, 3'd4, 3'd0, 3'd5, 32'h400, 32'h0, 32'h500, 1'b0);
            if (i == 0) expectIdle("fair.first");
            else if (i % 2 == 1) expectCdb("fair", 3'd4, 2'd0, 32'h400);
            else expectCdb("fair", 3'd5, 2'd2, 32'h500);
        end
        idle();
        expectCdb("fairDrain0", 3'd5, 2'd2, 32'h500);
        idle();
        expectCdb("fairDrain1", 3'd4, 2'd0, 32'h400);
        idle();
        expectCdb("fairDrain2", 3'd5, 2'd2, 32'h500);
        idle();
        expectIdle("fair.done");

        // Backpressure on unit 0 while units 1 and 2 compete.
        applyStimulus(3'b110, 3'd0, 3'd1, 3'd2, 32'h0, 32'h111, 32'h222, 1'b0);
        expectIdle("bp.b1");
        expectReady("bp.b1", 3'b111);
        applyStimulus(3'b111, 3'd5, 3'd1, 3'd2, 32'h555, 32'h111, 32'h222, 1'b0);
        expectCdb("bp.b2", 3'd1, 2'd1, 32'h111);
        expectReady("bp.b2", 3'b011);
        applyStimulus(3'b111, 3'd6, 3'd1, 3'd2, 32'h666, 32'h111, 32'h222, 1'b0);
        expectCdb("bp.b3", 3'd2, 2'd2, 32'h222);
        expectReady("bp.b3", 3'b100);
        applyStimulus(3'b111, 3'd7, 3'd1, 3'd2, 32'h777, 32'h111, 32'h222, 1'b0);
        expectCdb("bp.b4", 3'd5, 2'd0, 32'h555);
        expectReady("bp.b4", 3'b001);
        applyStimulus(3'b111, 3'd7, 3'd1, 3'd2, 32'h777, 32'h111, 32'h222, 1'b0);
        expectCdb("bp.b5", 3'd1, 2'd1, 32'h111);
        expectReady("bp.b5", 3'b010);
        idle();
        expectCdb("bp.b6", 3'd2, 2'd2, 32'h222);
        idle();
        expectCdb("bp.b7", 3'd6, 2'd0, 32'h666);
        idle();
        expectCdb("bp.b8", 3'd1, 2'd1, 32'h111);
        idle();
        expectCdb("bp.b9", 3'd2, 2'd2, 32'h222);
        idle();
        expectCdb("bp.b10", 3'd7, 2'd0, 32'h777);
        idle();
        expectIdle("bp.done");
        expectReady("bp.done", 3'b111);

        // Flush with two entries queued on unit 1 and a new push on unit 2.
        applyReset();
        applyStimulus(3'b011, 3'd3, 3'd4, 3'd0, 32'h33, 32'h44, 32'h0, 1'b0);
        expectIdle("fl.f1");
        applyStimulus(3'b010, 3'd0, 3'd5, 3'd0, 32'h0, 32'h55, 32'h0, 1'b0);
        expectCdb("fl.f2", 3'd3, 2'd0, 32'h33);
        expectReady("fl.f2", 3'b101);
        applyStimulus(3'b100, 3'd0, 3'd0, 3'd6, 32'h0, 32'h0, 32'h66, 1'b1);
        expectIdle("fl.f3");
        checkOutput("fl.f3.holdTag", 32'(bus.cdb_tag), 32'd3);
        expectReady("fl.f3", 3'b111);
        for (int i = 0; i < 2; i++) begin
            idle();
            expectIdle("fl.quiet");
            checkOutput("fl.quiet.tag", 32'(bus.cdb_tag), 32'd3);
        end
        // rr survives the flush, so unit 2 beats unit 0 here.
        applyStimulus(3'b101, 3'd1, 3'd0, 3'd2, 32'h10, 32'h0, 32'h20, 1'b0);
        expectIdle("fl.rrPush");
        idle();
        expectCdb("fl.rr0", 3'd2, 2'd2, 32'h20);
        idle();
        expectCdb("fl.rr1", 3'd1, 2'd0, 32'h10);
        idle();
        expectIdle("fl.done");

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer side of the Common Data Bus (CDB) in the Tomasulo core.
- Functional units (adder, multiplier, load unit) hand completed results (ROB/RS tag + 32-bit value) to this block.
- The block buffers each unit's results and broadcasts exactly one (tag, value) per cycle to the reservation stations, register status table and ROB, which are the CDB receivers.
- Arbitration between units is round-robin, so no unit starves.

Parameters:
- N_FU, 3, number of functional-unit sources.
- TAG_W, 3, width of the ROB/RS tag.
- DATA_W, 32, width of a result value.
- DEPTH, 2, per-source buffer depth in entries; must be a power of two, ≥1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- fu_valid  in  N_FU  per-unit result-valid.
- fu_ready  out  N_FU  per-unit buffer-not-full.
- fu_tag  in  N_FU*TAG_W  per-unit tag, unit i at bits [i*TAG_W +: TAG_W].
- fu_result  in  N_FU*DATA_W  per-unit value, same packing as fu_tag.
- flush  in  1  mispredict/exception squash.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag, registered.
- cdb_value  out  DATA_W  broadcast value, registered.
- cdb_src  out  clog2(N_FU)  index of the granted unit, registered; for debug/statistics.

Behaviour:
- Reset (RST_N=0 at an edge):
  - All FIFOs emptied; round-robin pointer rr=0.
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
  - fu_ready is all-ones from the first cycle after reset.
  - Reset takes priority over flush and over all pushes.
- Handshake:
  - Unit i transfers on an edge where fu_valid[i]=1 and fu_ready[i]=1.
  - fu_ready[i] = (count[i] < DEPTH), derived only from registered count. It has no combinational path from fu_valid or from the current cycle's pop.
  - While fu_ready[i]=0, the unit must hold fu_valid, fu_tag and fu_result stable.
- Per-source FIFO:
  - Circular, with wr_ptr/rd_ptr modulo DEPTH.
  - Push and pop in the same cycle are legal; count is unchanged in that case.
  - A full FIFO popped in a cycle still reports fu_ready=0 for that cycle (no bypass).
- Arbitration (combinational, each cycle):
  - Candidates are the FIFOs with count>0.
  - Search starts at index rr and proceeds upward modulo N_FU; the first candidate found wins.
  - The winner's head entry is popped.
  - At the edge: cdb_valid<=1, cdb_tag/cdb_value<=head, cdb_src<=winner, rr<=(winner+1) mod N_FU.
  - With no candidates: cdb_valid<=0, tag/value/src hold their previous values, rr unchanged.
- Latency:
  - A result accepted at edge k is broadcast no earlier than edge k+1, i.e. visible during cycle k+1..k+2.
  - There is no same-cycle bypass from fu_* to cdb_*.
- Throughput:
  - Exactly one broadcast per cycle whenever any FIFO is non-empty.
  - A single active unit sustains one result per cycle.
- Flush (flush=1 at an edge, RST_N=1):
  - All FIFOs are emptied; pushes in that cycle are discarded.
  - cdb_valid<=0; rr is preserved.
  - A broadcast that is already registered (visible this cycle) is not recalled.
- Tag/value are forwarded unchanged; no arithmetic is performed on them.
- Pointer and count widths are clog2(DEPTH)+1.

Decomposition:
- Shared package tomasulo_pkg holds:
  - TAG_W and DATA_W constants;
  - the cdb_pkt_t struct {valid, tag[TAG_W], value[DATA_W]}, also used by the receiver side;
  - FU index constants FU_ADD=0, FU_MUL=1, FU_LD=2.
- Sub-module cdb_src_fifo: a single-source DEPTH-entry FIFO with push/pop/full/empty/head. It is instantiated N_FU times via generate.
- The arbiter and output register live in the top level.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with fu_valid=3'b111 → cdb_valid=0, tag=0, value=0 throughout; fu_ready=3'b111 after release; no entry was captured.
- Single unit: push {tag=3, value=32'h0000_00A5} on unit 1 at edge k → cdb_valid=1, tag=3, value=A5, src=1 during cycle k+1; cdb_valid=0 the cycle after.
- Simultaneous push on all three units at the same edge (tags 1,2,3; values 10,20,30), rr=0 → broadcasts over 3 consecutive cycles in order src 0,1,2 with tags 1,2,3; rr ends at 0.
- Fairness: keep units 0 and 2 continuously valid for 6 cycles → CDB sources alternate 0,2,0,2,...; neither unit waits more than 1 cycle between grants.
- Backpressure: push 3 results on unit 0 while units 1 and 2 keep winning arbitration → fu_ready[0]=0 after 2 accepts; the third result is held stable and accepted only after unit 0's first broadcast; all 3 tags appear on the CDB in push order.
- Flush: 2 entries queued on unit 1, then assert flush for one edge together with a new push on unit 2 → no queued or newly pushed tag is ever broadcast; cdb_valid=0 the next cycle; fu_ready=3'b111.
